char_buffer_writer: RTL
=======================

Name: char_buffer_writer

Overview:
- Writer side of the on-screen character buffer. The character storage block reads this buffer to draw glyphs on the LCD.
- Converts push-button presses and the 7-bit switch value into writes of ASCII codes at a cursor position.
- Supports three operations: type a character, backspace, and clear the screen.
- Drives the write port of the text RAM. The display path only reads that RAM.

Parameters:
- COLS, 60, text columns (480 px / 8 px glyph)
- ROWS, 17, text rows (272 px / 16 px glyph)
- ADDR_W, 11, width of the buffer address; must satisfy 2^ADDR_W >= COLS*ROWS
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a level change (5 ms at 50 MHz)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- btn  in  3  raw push buttons, active-low; [0]=type, [1]=backspace, [2]=clear
- sw  in  7  ASCII code to type
- wr_en  out  1  one-cycle write strobe to the text RAM
- wr_addr  out  ADDR_W  write address = row*COLS + col
- wr_data  out  7  ASCII code to write
- cursor_col  out  6  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- busy  out  1  high while a clear sweep is running

Behaviour:
- Reset is asynchronous and active-high. Reset values: wr_en=0, wr_addr=0, wr_data=0x20, cursor_col=0, cursor_row=0, busy=0. State goes to IDLE.
- Reset asserted mid-sweep aborts the sweep immediately. No further writes occur.
- Input conditioning, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - A one-cycle press event fires on the debounced released->pressed edge.
  - No further event until the button is released, the release is debounced, and it is pressed again.
- State machine:
  - IDLE: on a press event, take the highest-priority event: clear > backspace > type. Lower-priority events in the same cycle are discarded.
  - Type: in the next cycle, wr_en=1, wr_addr=cursor, wr_data=sw sampled in the event cycle. Cursor then advances. Returns to IDLE.
  - Backspace: cursor moves back one position. In the next cycle, wr_en=1 at the new position with wr_data=0x20. Returns to IDLE.
  - Clear (CLEAR state): busy=1. One write per cycle with wr_data=0x20 at addresses 0, 1, ..., COLS*ROWS-1. After the last write, busy=0, cursor=(0,0), return to IDLE.
- Latency:
  - Type and backspace: wr_en is high exactly one cycle, in the cycle after the press event.
  - Cursor outputs update in the same cycle as wr_en.
  - Clear: the first sweep write occurs in the cycle after the event; the sweep lasts exactly COLS*ROWS cycles.
- Cursor arithmetic and wrap:
  - Advance: col+1. At col=COLS-1, go to col=0, row+1. At (COLS-1, ROWS-1), wrap to (0,0).
  - Backspace: col-1. At col=0, go to col=COLS-1, row-1. At (0,0), stay at (0,0) and still write a space at address 0.
- Press events that occur while busy=1 are dropped, not queued.
- wr_addr is registered and equals cursor_row*COLS+cursor_col, or the sweep index during a clear. It never exceeds COLS*ROWS-1.

Optional Feature:
- Macro: CHAR_WRITER_AUTOCLEAR_EN.
- Defined: on reset deassertion, the block enters CLEAR automatically and runs one full sweep (busy=1 for COLS*ROWS cycles), exactly as for a clear button press. This wipes power-up RAM garbage.
- Not defined: the block stays in IDLE after reset and writes nothing until a button press.

Test Plan:
- DEBOUNCE_CYCLES=4, sw=0x41, btn[0] low for 20 cycles -> exactly one wr_en pulse, wr_addr=0, wr_data=0x41, cursor becomes (1,0). Bounce of btn[0] (toggling every 2 cycles) -> no event.
- 60 type presses from (0,0) -> last write at addr 59, cursor (0,1). A press at (59,16) -> write at addr 1019, cursor wraps to (0,0).
- Backspace at (0,1) -> wr_addr=59, wr_data=0x20, cursor (59,0). Backspace at (0,0) -> wr_addr=0, wr_data=0x20, cursor remains (0,0).
- btn[2] pressed -> busy high 1020 cycles, wr_en every cycle, addresses 0..1019, data 0x20, then cursor (0,0). btn[0] pressed mid-sweep -> no extra write afterwards.
- btn[0], btn[1], btn[2] pressed in the same cycle -> clear sweep only. Reset asserted at sweep address 500 -> wr_en=0 immediately, all outputs at reset values.
- With CHAR_WRITER_AUTOCLEAR_EN defined: release reset -> sweep of 1020 writes without any button. Without the macro -> no wr_en for 2000 cycles.

Source files
------------

// File: rtl/char_buffer_writer.sv
// -----------------------------------------------------------------------------
// char_buffer_writer
// Writer side of the on-screen character buffer. Turns push-button presses and
// the switch value into ASCII writes at a cursor position of the text RAM that
// the display path reads.
//
// Operations: type (btn[0]), backspace (btn[1]), clear screen (btn[2]).
// Priority when several presses land in the same cycle: clear > backspace > type.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   reset      in   asynchronous, active-high reset
//   btn[2:0]   in   raw active-low push buttons
//   sw[6:0]    in   ASCII code to type
//   wr_en      out  one-cycle write strobe to the text RAM
//   wr_addr    out  write address (row*COLS+col, or sweep index while clearing)
//   wr_data    out  ASCII code to write
//   cursor_col out  current column 0..COLS-1
//   cursor_row out  current row 0..ROWS-1
//   busy       out  high while a clear sweep runs
//
// Optional feature (macro CHAR_WRITER_AUTOCLEAR_EN): when defined, one full
// clear sweep runs automatically after reset is released.
// -----------------------------------------------------------------------------
module char_buffer_writer #(
    parameter int COLS            = 60,
    parameter int ROWS            = 17,
    parameter int ADDR_W          = 11,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        btn,
    input  logic [6:0]        sw,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]        COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        SPACE     = 7'h20;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Button conditioning: levels are kept active-high (1 = pressed).
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       deb_r;
    logic [2:0]       press_r;
    logic [CNT_W-1:0] cnt_r [3];

    state_t            state_r;
    state_t            state_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [6:0]        wr_data_s;
    logic [5:0]        col_s;
    logic [4:0]        row_s;
    logic              busy_s;
    logic              auto_start_s;

    logic [ADDR_W-1:0] cur_addr_s;
    logic [ADDR_W-1:0] bk_addr_s;
    logic [5:0]        adv_col_s;
    logic [4:0]        adv_row_s;
    logic [5:0]        bk_col_s;
    logic [4:0]        bk_row_s;

`ifdef CHAR_WRITER_AUTOCLEAR_EN
    logic auto_pend_r;

    // One-shot request that starts a sweep in the first cycle after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_pend_r <= 1'b1;
        end else begin
            auto_pend_r <= 1'b0;
        end
    end

    assign auto_start_s = auto_pend_r;
`else
    assign auto_start_s = 1'b0;
`endif

    // Two-flop synchronizer for the inverted (active-high) button levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= ~btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a level only after DEBOUNCE_CYCLES differing samples in
    // a row; emit a one-cycle press pulse on an accepted released->pressed edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r   <= 3'b000;
            press_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                press_r[i] <= 1'b0;
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DB_LAST) begin
                    cnt_r[i]   <= '0;
                    deb_r[i]   <= sync2_r[i];
                    press_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Cursor neighbours and addresses; backspace at the origin stays put.
    always_comb begin
        cur_addr_s = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
        adv_col_s  = cursor_col + 6'd1;
        adv_row_s  = cursor_row;
        bk_col_s   = cursor_col - 6'd1;
        bk_row_s   = cursor_row;
        if (cur_addr_s == {ADDR_W{1'b0}}) begin
            bk_addr_s = {ADDR_W{1'b0}};
        end else begin
            bk_addr_s = cur_addr_s - {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (cursor_col == COL_LAST) begin
            adv_col_s = 6'd0;
            if (cursor_row == ROW_LAST) begin
                adv_row_s = 5'd0;
            end else begin
                adv_row_s = cursor_row + 5'd1;
            end
        end else begin
            adv_row_s = cursor_row;
        end
        if (cursor_col == 6'd0) begin
            if (cursor_row == 5'd0) begin
                bk_col_s = 6'd0;
                bk_row_s = 5'd0;
            end else begin
                bk_col_s = COL_LAST;
                bk_row_s = cursor_row - 5'd1;
            end
        end else begin
            bk_row_s = cursor_row;
        end
    end

    // Next-state and next-output logic; outputs hold unless an operation fires.
    always_comb begin
        state_s   = state_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr;
        wr_data_s = wr_data;
        col_s     = cursor_col;
        row_s     = cursor_row;
        busy_s    = busy;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (press_r[2] || auto_start_s) begin
                    state_s   = CLEAR;
                    busy_s    = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = {ADDR_W{1'b0}};
                    wr_data_s = SPACE;
                end else if (press_r[1]) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = bk_addr_s;
                    wr_data_s = SPACE;
                    col_s     = bk_col_s;
                    row_s     = bk_row_s;
                end else if (press_r[0]) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_addr_s;
                    wr_data_s = sw;
                    col_s     = adv_col_s;
                    row_s     = adv_row_s;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            CLEAR: begin
                // Presses arriving here are simply not looked at (dropped).
                wr_data_s = SPACE;
                if (wr_addr == ADDR_LAST) begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                    wr_en_s   = 1'b0;
                    wr_addr_s = {ADDR_W{1'b0}};
                    col_s     = 6'd0;
                    row_s     = 5'd0;
                end else begin
                    busy_s    = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= {ADDR_W{1'b0}};
            wr_data    <= SPACE;
            cursor_col <= 6'd0;
            cursor_row <= 5'd0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_en      <= wr_en_s;
            wr_addr    <= wr_addr_s;
            wr_data    <= wr_data_s;
            cursor_col <= col_s;
            cursor_row <= row_s;
            busy       <= busy_s;
        end
    end

endmodule
